// File: rtl/core_demux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_demux_pkg : shared types and constants for the core data-port demux
// rev 1.0
// ---------------------------------------------------------------------------
package core_demux_pkg;

  localparam int unsigned DEF_NUM_TARGETS = 4;
  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam logic [31:0] DEF_ERR_DATA    = 32'hBADACCE5;

  // Index width able to hold every target plus the error slot.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  typedef logic [$clog2(DEF_NUM_TARGETS + 1)-1:0] tgt_idx_t;

  localparam tgt_idx_t ERR_IDX = tgt_idx_t'(DEF_NUM_TARGETS);

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] base;
    logic [DEF_ADDR_WIDTH-1:0] mask;
    logic                      en;
  } rule_t;

endpackage
`default_nettype wire

// File: rtl/core_demux_addr_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_demux_addr_decoder : base/mask rule match, lowest matching rule wins
// rev 1.0
// ---------------------------------------------------------------------------
module core_demux_addr_decoder
  import core_demux_pkg::*;
#(
  parameter int unsigned AddrWidth  = DEF_ADDR_WIDTH,
  parameter int unsigned NumTargets = DEF_NUM_TARGETS,
  localparam int unsigned IdxWidth  = idx_width(NumTargets)
) (
  input  logic [NumTargets*AddrWidth-1:0] rule_base_i,
  input  logic [NumTargets*AddrWidth-1:0] rule_mask_i,
  input  logic [NumTargets-1:0]           rule_en_i,
  input  logic [AddrWidth-1:0]            add_i,
  output logic [NumTargets-1:0]           hit_o,
  output logic [IdxWidth-1:0]             sel_o
);

  for (genvar i = 0; i < NumTargets; i++) begin : g_rule
    logic [AddrWidth-1:0] mask;
    assign mask     = rule_mask_i[i*AddrWidth +: AddrWidth];
    assign hit_o[i] = rule_en_i[i] &
                      ((add_i & mask) == (rule_base_i[i*AddrWidth +: AddrWidth] & mask));
  end

  // Walk from the top down so the lowest hitting index is the last write.
  always_comb begin
    sel_o = IdxWidth'(NumTargets);
    for (int i = NumTargets - 1; i >= 0; i--) begin
      if (hit_o[i]) sel_o = IdxWidth'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_data_demux_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_data_demux_n : in-order N-way demux of one core data port to slaves
// rev 1.0
// ---------------------------------------------------------------------------
module core_data_demux_n
  import core_demux_pkg::*;
#(
  parameter int unsigned AddrWidth      = DEF_ADDR_WIDTH,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumTargets     = DEF_NUM_TARGETS,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [DataWidth-1:0] ErrData = DataWidth'(DEF_ERR_DATA),
  localparam int unsigned BeWidth       = DataWidth / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumTargets*AddrWidth-1:0]  rule_base_i,
  input  logic [NumTargets*AddrWidth-1:0]  rule_mask_i,
  input  logic [NumTargets-1:0]            rule_en_i,
  input  logic                             req_i,
  input  logic [AddrWidth-1:0]             add_i,
  input  logic                             we_i,
  input  logic [DataWidth-1:0]             wdata_i,
  input  logic [BeWidth-1:0]               be_i,
  output logic                             gnt_o,
  output logic                             r_valid_o,
  output logic [DataWidth-1:0]             r_rdata_o,
  output logic                             r_err_o,
  output logic [NumTargets-1:0]            tgt_req_o,
  output logic [NumTargets*AddrWidth-1:0]  tgt_add_o,
  output logic [NumTargets-1:0]            tgt_wen_o,
  output logic [NumTargets*DataWidth-1:0]  tgt_wdata_o,
  output logic [NumTargets*BeWidth-1:0]    tgt_be_o,
  input  logic [NumTargets-1:0]            tgt_gnt_i,
  input  logic [NumTargets-1:0]            tgt_r_valid_i,
  input  logic [NumTargets*DataWidth-1:0]  tgt_r_rdata_i,
  output logic [NumTargets-1:0]            perf_ld_o,
  output logic [NumTargets-1:0]            perf_st_o,
  output logic                             perf_stall_o
);

  localparam int unsigned IdxWidth = idx_width(NumTargets);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [IdxWidth-1:0] ErrIdx = IdxWidth'(NumTargets);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [IdxWidth-1:0]   cur_q, cur_d;
  logic                  err_pend_q, err_pend_d;
  logic                  ready_q, ready_d;

  logic [NumTargets-1:0] hit;
  logic [IdxWidth-1:0]   sel;
  logic                  sel_is_err, cur_is_err, cnt_nz;
  logic                  tgt_gnt_sel, cur_valid;
  logic [DataWidth-1:0]  cur_rdata;
  logic                  order_ok, issue_ok, push, pop;

  core_demux_addr_decoder #(
    .AddrWidth  (AddrWidth),
    .NumTargets (NumTargets)
  ) u_decoder (
    .rule_base_i (rule_base_i),
    .rule_mask_i (rule_mask_i),
    .rule_en_i   (rule_en_i),
    .add_i       (add_i),
    .hit_o       (hit),
    .sel_o       (sel)
  );

  assign sel_is_err = (sel == ErrIdx);
  assign cur_is_err = (cur_q == ErrIdx);
  assign cnt_nz     = (cnt_q != '0);

  // Per-target grant of the decoded slave and response of the current slave.
  always_comb begin
    tgt_gnt_sel = 1'b0;
    cur_valid   = 1'b0;
    cur_rdata   = '0;
    for (int i = 0; i < NumTargets; i++) begin
      if (sel == IdxWidth'(i)) tgt_gnt_sel = tgt_gnt_i[i];
      if (cur_q == IdxWidth'(i)) begin
        cur_valid = tgt_r_valid_i[i];
        cur_rdata = tgt_r_rdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  assign pop = ready_q & (cur_is_err ? err_pend_q : (cur_valid & cnt_nz));

  // A switch of target may go out in the very cycle the last in-flight
  // response of the previous target returns, so ordering is preserved.
  assign order_ok = ~cnt_nz | (sel == cur_q) | (pop & (cnt_q == CntOne));
  assign issue_ok = ready_q & (cnt_q < CntMax) & order_ok;
  assign gnt_o    = issue_ok & req_i & (sel_is_err | tgt_gnt_sel);
  assign push     = gnt_o;

  assign r_valid_o    = pop;
  assign r_err_o      = pop & cur_is_err;
  assign r_rdata_o    = !ready_q ? '0 : (cur_is_err ? ErrData : cur_rdata);
  assign perf_stall_o = ready_q & req_i & ~issue_ok;

  for (genvar i = 0; i < NumTargets; i++) begin : g_tgt
    logic is_sel;
    assign is_sel       = (sel == IdxWidth'(i));
    assign tgt_req_o[i] = issue_ok & req_i & is_sel;
    assign tgt_wen_o[i] = ~we_i;
    assign tgt_add_o[i*AddrWidth +: AddrWidth]   = add_i;
    assign tgt_wdata_o[i*DataWidth +: DataWidth] = wdata_i;
    assign tgt_be_o[i*BeWidth +: BeWidth]        = be_i;
    assign perf_ld_o[i] = push & is_sel & ~we_i;
    assign perf_st_o[i] = push & is_sel &  we_i;
  end

  always_comb begin
    ready_d    = 1'b1;
    cur_d      = push ? sel : cur_q;
    err_pend_d = (push & sel_is_err) | (err_pend_q & ~pop);
    cnt_d      = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      cur_q      <= '0;
      err_pend_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      err_pend_q <= err_pend_d;
      ready_q    <= ready_d;
    end
  end

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntMax);

  a_sel_hit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sel_is_err == (hit == '0));

  for (genvar i = 0; i < NumTargets; i++) begin : g_rsp_chk
    a_rsp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
      tgt_r_valid_i[i] |-> (cnt_q != '0 && cur_q == IdxWidth'(i)));
  end

endmodule
`default_nettype wire

// File: tb/tb_core_data_demux_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_core_data_demux_n : vector table plus scoreboarded slave model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_core_data_demux_n;

  localparam int NT = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam logic [31:0] ERR_DATA = 32'hBADACCE5;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [NT*AW-1:0] rule_base_i, rule_mask_i;
  logic [NT-1:0]    rule_en_i;
  logic             req_i, we_i;
  logic [AW-1:0]    add_i;
  logic [DW-1:0]    wdata_i;
  logic [BW-1:0]    be_i;
  logic             gnt_o, r_valid_o, r_err_o, perf_stall_o;
  logic [DW-1:0]    r_rdata_o;
  logic [NT-1:0]    tgt_req_o, tgt_wen_o, perf_ld_o, perf_st_o;
  logic [NT*AW-1:0] tgt_add_o;
  logic [NT*DW-1:0] tgt_wdata_o, tgt_r_rdata_i;
  logic [NT*BW-1:0] tgt_be_o;
  logic [NT-1:0]    tgt_gnt_i, tgt_r_valid_i;

  core_data_demux_n #(
    .AddrWidth(AW), .DataWidth(DW), .NumTargets(NT), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rule_base_i(rule_base_i), .rule_mask_i(rule_mask_i), .rule_en_i(rule_en_i),
    .req_i(req_i), .add_i(add_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
    .tgt_req_o(tgt_req_o), .tgt_add_o(tgt_add_o), .tgt_wen_o(tgt_wen_o),
    .tgt_wdata_o(tgt_wdata_o), .tgt_be_o(tgt_be_o), .tgt_gnt_i(tgt_gnt_i),
    .tgt_r_valid_i(tgt_r_valid_i), .tgt_r_rdata_i(tgt_r_rdata_i),
    .perf_ld_o(perf_ld_o), .perf_st_o(perf_st_o), .perf_stall_o(perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] data; logic err; } exp_t;
  typedef struct {
    logic [31:0] addr; logic we; logic [3:0] be;
    logic [3:0] exp_req; logic exp_gnt; logic [3:0] exp_ld; logic [3:0] exp_st;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] slv_q[NT][$];
  logic [NT-1:0] hold;
  int          errors = 0, checks = 0, rsp_cnt = 0, seq = 0;

  // snapshot of DUT outputs taken mid-cycle
  logic        s_gnt, s_rv, s_err, s_stall;
  logic [31:0] s_rdata;
  logic [3:0]  s_req, s_ld, s_st, s_wen, s_be0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic slave_drive();
    for (int i = 0; i < NT; i++) begin
      tgt_r_valid_i[i] = (slv_q[i].size() > 0) && !hold[i];
      if (slv_q[i].size() > 0) tgt_r_rdata_i[i*DW +: DW] = slv_q[i][0];
    end
  endtask

  task automatic tick();
    logic [NT-1:0] rv_s;
    exp_t e;
    logic [31:0] d;
    @(negedge clk_i);
    s_gnt = gnt_o; s_rv = r_valid_o; s_err = r_err_o; s_stall = perf_stall_o;
    s_rdata = r_rdata_o; s_req = tgt_req_o; s_ld = perf_ld_o; s_st = perf_st_o;
    s_wen = tgt_wen_o; s_be0 = tgt_be_o[3:0];
    if (r_valid_o) begin
      rsp_cnt++;
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_data", r_rdata_o, e.data);
        chk("rsp_err", {31'd0, r_err_o}, {31'd0, e.err});
      end
    end
    for (int i = 0; i < NT; i++) begin
      if (tgt_req_o[i] && tgt_gnt_i[i]) begin
        seq++;
        d = 32'h5A00_0000 + (i << 20) + seq;
        slv_q[i].push_back(d);
        exp_q.push_back('{d, 1'b0});
      end
    end
    if (gnt_o && tgt_req_o == '0) exp_q.push_back('{ERR_DATA, 1'b1});
    rv_s = tgt_r_valid_i;
    @(posedge clk_i); #1;
    for (int i = 0; i < NT; i++) if (rv_s[i]) void'(slv_q[i].pop_front());
    slave_drive();
  endtask

  task automatic drain();
    req_i = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] b);
    req_i = 1'b1; add_i = a; we_i = w; be_i = b; wdata_i = a ^ 32'hFFFF_0000;
  endtask

  vec_t vecs[6];
  int   rsp0;

  initial begin
    vecs[0] = '{32'h0000_0100, 1'b0, 4'hF, 4'b0001, 1'b1, 4'b0001, 4'b0000};
    vecs[1] = '{32'h00F0_0000, 1'b0, 4'hF, 4'b0100, 1'b1, 4'b0100, 4'b0000};
    vecs[2] = '{32'h1020_0004, 1'b1, 4'hF, 4'b0010, 1'b1, 4'b0000, 4'b0010};
    vecs[3] = '{32'h2ABC_0000, 1'b0, 4'hF, 4'b1000, 1'b1, 4'b1000, 4'b0000};
    vecs[4] = '{32'hDEAD_0000, 1'b0, 4'hF, 4'b0000, 1'b1, 4'b0000, 4'b0000};
    vecs[5] = '{32'h0000_0040, 1'b1, 4'b0011, 4'b0001, 1'b1, 4'b0000, 4'b0001};

    // rule0 0x000xxxxx, rule1 0x102xxxxx, rule2 0x00xxxxxx (overlaps rule0), rule3 0x2xxxxxxx
    rule_base_i = {32'h2000_0000, 32'h0000_0000, 32'h1020_0000, 32'h0000_0000};
    rule_mask_i = {32'hF000_0000, 32'hFF00_0000, 32'hFFF0_0000, 32'hFFF0_0000};
    rule_en_i   = 4'hF;
    tgt_gnt_i = 4'hF; tgt_r_valid_i = '0; tgt_r_rdata_i = {4{32'h1111_1111}};
    hold = '0; rst_ni = 1'b0;
    drive(32'h0000_0100, 1'b0, 4'hF);
    @(posedge clk_i); #1;

    // reset: everything quiet, grant only from the 2nd cycle after release
    tick();
    chk("rst_gnt", s_gnt, 0); chk("rst_tgt_req", s_req, 0); chk("rst_rvalid", s_rv, 0);
    chk("rst_rdata", s_rdata, 0); chk("rst_stall", s_stall, 0); chk("rst_ld", s_ld, 0);
    rst_ni = 1'b1;
    tick(); chk("rel_c1_gnt", s_gnt, 0);
    tick(); chk("rel_c2_gnt", s_gnt, 1); chk("rel_c2_req", s_req, 4'b0001);
    drain();

    // decode table, one transaction at a time
    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].addr, vecs[v].we, vecs[v].be);
      tick();
      chk($sformatf("v%0d_req", v), s_req, vecs[v].exp_req);
      chk($sformatf("v%0d_gnt", v), s_gnt, vecs[v].exp_gnt);
      chk($sformatf("v%0d_ld", v), s_ld, vecs[v].exp_ld);
      chk($sformatf("v%0d_st", v), s_st, vecs[v].exp_st);
      chk($sformatf("v%0d_wen", v), s_wen, {4{~vecs[v].we}});
      if (v == 5) chk("v5_be0", s_be0, 4'b0011);
      drain();
    end

    // back-to-back loads to target 1
    rsp0 = rsp_cnt;
    for (int k = 0; k < 4; k++) begin
      drive(32'h1020_0004, 1'b0, 4'hF);
      tick();
      chk($sformatf("b2b%0d_gnt", k), s_gnt, 1);
      chk($sformatf("b2b%0d_ld", k), s_ld, 4'b0010);
      chk($sformatf("b2b%0d_rv", k), s_rv, (k > 0) ? 1 : 0);
    end
    drain();
    chk("b2b_rsp_count", rsp_cnt - rsp0, 4);

    // full at MaxOutstanding=2
    hold[1] = 1'b1;
    drive(32'h1020_0008, 1'b0, 4'hF);
    tick(); chk("full_g1", s_gnt, 1);
    tick(); chk("full_g2", s_gnt, 1);
    tick(); chk("full_blk_gnt", s_gnt, 0); chk("full_blk_stall", s_stall, 1); chk("full_blk_req", s_req, 0);
    tick(); chk("full_blk2_stall", s_stall, 1);
    hold[1] = 1'b0; slave_drive();
    tick(); chk("full_pop_rv", s_rv, 1); chk("full_pop_stall", s_stall, 1);
    tick(); chk("full_after_gnt", s_gnt, 1); chk("full_after_stall", s_stall, 0);
    drain();

    // ordering: tgt2 waits for tgt0, then goes in the pop cycle
    hold[0] = 1'b1;
    drive(32'h0000_0100, 1'b0, 4'hF);
    tick(); chk("ord_g0", s_gnt, 1);
    drive(32'h00F0_0000, 1'b0, 4'hF);
    tick(); chk("ord_blk_gnt", s_gnt, 0); chk("ord_blk_stall", s_stall, 1);
    tick(); chk("ord_blk2_req", s_req, 0);
    hold[0] = 1'b0; slave_drive();
    tick(); chk("ord_pop_rv", s_rv, 1); chk("ord_pop_gnt", s_gnt, 1); chk("ord_pop_req", s_req, 4'b0100);
    drain();

    // unmapped access, single then back-to-back
    drive(32'hDEAD_0000, 1'b0, 4'hF);
    tick(); chk("err_gnt", s_gnt, 1); chk("err_req", s_req, 0); chk("err_ld", s_ld, 0);
    req_i = 1'b0;
    tick(); chk("err_rv", s_rv, 1); chk("err_rdata", s_rdata, ERR_DATA); chk("err_flag", s_err, 1);
    drive(32'hDEAD_0000, 1'b1, 4'hF);
    tick(); chk("err2a_gnt", s_gnt, 1);
    tick(); chk("err2b_gnt", s_gnt, 1); chk("err2b_rv", s_rv, 1); chk("err2b_st", s_st, 0);
    req_i = 1'b0;
    tick(); chk("err2_last_rv", s_rv, 1); chk("err2_last_flag", s_err, 1);
    drain();

    // reset while a load is outstanding; late response must be dropped
    hold[0] = 1'b1;
    drive(32'h0000_0200, 1'b0, 4'hF);
    tick(); chk("mid_g", s_gnt, 1);
    req_i = 1'b0; rst_ni = 1'b0; hold[0] = 1'b0; slave_drive();
    tick(); chk("mid_rst_rv", s_rv, 0);
    exp_q.delete();
    for (int i = 0; i < NT; i++) slv_q[i].delete();
    slave_drive();
    rst_ni = 1'b1;
    tick();
    drive(32'h2000_0010, 1'b0, 4'hF);
    tick(); chk("mid_after_gnt", s_gnt, 1); chk("mid_after_req", s_req, 4'b1000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
